// File: rtl/encoder_arb_pkg.sv
// Shared types and default sizing for the round-robin encoder arbiter.
// The state enum is also used by the bench to decode the exposed FSM state.
package encoder_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      OWN   = 2'd1,
      YIELD = 2'd2
   } arb_state_t;

   localparam int DEF_N_REQ    = 16;
   localparam int DEF_MAX_HOLD = 8;

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating-priority picker: the first set request at or after
// ptr+1 (mod N) wins; the bit at ptr itself has the lowest priority.
module rr_pick #(
   parameter int N  = 16,
   parameter int IW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  pick,
   output logic [IW-1:0] idx,
   output logic          any
);

   logic [IW-1:0] pos;

   // Walk from lowest to highest priority so the last hit is the winner.
   // Offset N truncates to ptr itself, which is the lowest-priority slot.
   always_comb begin
      idx = '0;
      pos = '0;
      for (int i = N; i >= 1; i--) begin
         pos = ptr + IW'(i);
         if (req[pos]) begin
            idx = pos;
         end
      end
      any  = |req;
      pick = any ? (N'(1) << idx) : '0;
   end

endmodule

// File: rtl/encoder_rr_arbiter.sv
// Round-robin arbiter in front of a shared one-hot-to-binary encoder, with a
// per-owner hold limit that forces a one-cycle yield when others are waiting.
module encoder_rr_arbiter
   import encoder_arb_pkg::*;
#(
   parameter  int N_REQ    = DEF_N_REQ,
   parameter  int MAX_HOLD = DEF_MAX_HOLD,
   localparam int IDX_W    = $clog2(N_REQ),
   localparam int CNT_W    = $clog2(MAX_HOLD + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_REQ-1:0] req,
   output logic [N_REQ-1:0] grant,
   output logic [IDX_W-1:0] grant_idx,
   output logic             grant_valid,
   output logic             enc_enable,
   output arb_state_t       state
);

   localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(MAX_HOLD - 1);

   logic [CNT_W-1:0] hold_cnt;
   logic [IDX_W-1:0] last_owner;
   logic [N_REQ-1:0] pick;
   logic [IDX_W-1:0] pick_idx;
   logic             pick_any;
   logic             others_waiting;

   rr_pick #(
      .N  (N_REQ),
      .IW (IDX_W)
   ) u_pick (
      .req  (req),
      .ptr  (last_owner),
      .pick (pick),
      .idx  (pick_idx),
      .any  (pick_any)
   );

   assign others_waiting = |(req & ~grant);

   // Handshake: req is level-sensitive and may change any cycle; a requester
   // owns the encoder for every cycle its grant bit is high, and grant,
   // grant_idx, grant_valid and enc_enable always come from the same decision.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         grant       <= '0;
         grant_idx   <= '0;
         grant_valid <= 1'b0;
         enc_enable  <= 1'b0;
         hold_cnt    <= '0;
         last_owner  <= IDX_W'(N_REQ - 1);
      end else begin
         case (state)
            IDLE, YIELD: begin
               if (pick_any) begin
                  state       <= OWN;
                  grant       <= pick;
                  grant_idx   <= pick_idx;
                  grant_valid <= 1'b1;
                  enc_enable  <= 1'b1;
                  hold_cnt    <= '0;
                  last_owner  <= pick_idx;
               end else begin
                  state       <= IDLE;
                  grant       <= '0;
                  grant_idx   <= '0;
                  grant_valid <= 1'b0;
                  enc_enable  <= 1'b0;
               end
            end

            OWN: begin
               if (!req[grant_idx]) begin
                  // The owner is still last_owner, so the picker already
                  // starts just past it and cannot reselect the dropped bit.
                  if (pick_any) begin
                     state       <= OWN;
                     grant       <= pick;
                     grant_idx   <= pick_idx;
                     grant_valid <= 1'b1;
                     enc_enable  <= 1'b1;
                     hold_cnt    <= '0;
                     last_owner  <= pick_idx;
                  end else begin
                     state       <= IDLE;
                     grant       <= '0;
                     grant_idx   <= '0;
                     grant_valid <= 1'b0;
                     enc_enable  <= 1'b0;
                  end
               end else if (hold_cnt >= HOLD_LIM) begin
                  if (others_waiting) begin
                     state       <= YIELD;
                     grant       <= '0;
                     grant_idx   <= '0;
                     grant_valid <= 1'b0;
                     enc_enable  <= 1'b0;
                  end
               end else begin
                  hold_cnt <= hold_cnt + CNT_W'(1);
               end
            end

            default: begin
               state       <= IDLE;
               grant       <= '0;
               grant_idx   <= '0;
               grant_valid <= 1'b0;
               enc_enable  <= 1'b0;
               hold_cnt    <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_encoder_rr_arbiter.sv
// Self-checking bench for encoder_rr_arbiter: reference model feeds an expected
// queue at drive time, DUT outputs are popped and compared after each edge.
module tb_encoder_rr_arbiter;
   import encoder_arb_pkg::*;

   localparam int N_REQ    = 16;
   localparam int MAX_HOLD = 8;
   localparam int IDX_W    = $clog2(N_REQ);

   logic             clk;
   logic             rst_n;
   logic [N_REQ-1:0] req;
   logic [N_REQ-1:0] grant;
   logic [IDX_W-1:0] grant_idx;
   logic             grant_valid;
   logic             enc_enable;
   arb_state_t       state;

   int n_checks = 0;
   int n_pass   = 0;

   logic [N_REQ-1:0] exp_q[$];
   logic [IDX_W-1:0] exp_idx_q[$];
   logic [1:0]       exp_state_q[$];

   int m_owner, m_last, m_cnt, m_state;

   encoder_rr_arbiter #(
      .N_REQ    (N_REQ),
      .MAX_HOLD (MAX_HOLD)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req         (req),
      .grant       (grant),
      .grant_idx   (grant_idx),
      .grant_valid (grant_valid),
      .enc_enable  (enc_enable),
      .state       (state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
   endtask

   function automatic logic [N_REQ-1:0] oh(input int i);
      if (i < 0) return '0;
      return N_REQ'(1) << i;
   endfunction

   // reference model
   function automatic int model_pick(input logic [N_REQ-1:0] r);
      for (int k = 1; k <= N_REQ; k++) begin
         int c;
         c = (m_last + k) % N_REQ;
         if (r[c]) return c;
      end
      return -1;
   endfunction

   task automatic model_reset();
      m_owner = -1;
      m_last  = N_REQ - 1;
      m_cnt   = 0;
      m_state = 0;
   endtask

   task automatic model_step(input logic [N_REQ-1:0] r);
      int p;
      p = model_pick(r);
      if (m_state != 1 || !r[m_owner]) begin
         if (p >= 0) begin
            m_owner = p; m_last = p; m_cnt = 0; m_state = 1;
         end else begin
            m_owner = -1; m_state = 0;
         end
      end else if (m_cnt >= MAX_HOLD - 1) begin
         if ((r & ~oh(m_owner)) != '0) begin
            m_owner = -1; m_state = 2;
         end
      end else begin
         m_cnt++;
      end
   endtask

   task automatic check_invariants();
      check("onehot", 32'($countones(grant) <= 1), 32'd1);
      check("valid_eq_or", 32'(grant_valid), 32'(|grant));
      check("enc_eq_valid", 32'(enc_enable), 32'(grant_valid));
      check("idx_vs_grant", 32'(grant), 32'(grant_valid ? oh(int'(grant_idx)) : '0));
   endtask

   // driver: one cycle of stimulus, expectation pushed, then popped and compared
   task automatic step(input logic [N_REQ-1:0] r);
      @(negedge clk);
      req = r;
      model_step(r);
      exp_q.push_back(oh(m_owner));
      exp_idx_q.push_back(m_owner < 0 ? '0 : IDX_W'(m_owner));
      exp_state_q.push_back(2'(m_state));
      @(posedge clk);
      #1;
      check("grant", 32'(grant), 32'(exp_q.pop_front()));
      check("grant_idx", 32'(grant_idx), 32'(exp_idx_q.pop_front()));
      check("state", 32'(state), 32'(exp_state_q.pop_front()));
      check_invariants();
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      req   = '0;
      #1;
      check("rst_grant", 32'(grant), 32'd0);
      check("rst_idx", 32'(grant_idx), 32'd0);
      check("rst_valid", 32'(grant_valid), 32'd0);
      check("rst_enc", 32'(enc_enable), 32'd0);
      check("rst_state", 32'(state), 32'(IDLE));
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
   endtask

   initial begin
      logic [N_REQ-1:0] r;
      rst_n = 1'b0;
      req   = '0;
      model_reset();
      do_reset();

      // first grant after reset goes to req[0], then direct handover to 2
      step(16'h0005);
      check("d028_g0", 32'(grant), 32'h0001);
      check("d028_i0", 32'(grant_idx), 32'd0);
      step(16'h0004);
      check("d028_g1", 32'(grant), 32'h0004);
      check("d028_i1", 32'(grant_idx), 32'd2);

      // idle when nothing requested
      step(16'h0000);
      check("idle_g", 32'(grant), 32'd0);

      // owner 3 drops while req[1] is set: wrap to 1 with no idle cycle
      do_reset();
      step(16'h0008);
      check("d031_own3", 32'(grant), 32'h0008);
      step(16'h000A);
      step(16'h0002);
      check("d031_wrap", 32'(grant), 32'h0002);
      check("d031_idx", 32'(grant_idx), 32'd1);

      // all requesting: 8 grant cycles, 1 yield cycle, owners 0..15,0
      do_reset();
      for (int k = 0; k < 17 * (MAX_HOLD + 1) - 1; k++) begin
         step(16'hFFFF);
         check("d029_rot", 32'(grant),
               32'((k % (MAX_HOLD + 1)) < MAX_HOLD ? oh((k / (MAX_HOLD + 1)) % N_REQ) : '0));
      end

      // lone requester never yields
      do_reset();
      for (int k = 0; k < 20; k++) begin
         step(16'h8000);
         check("d030_g", 32'(grant), 32'h8000);
         check("d030_i", 32'(grant_idx), 32'd15);
      end

      // asynchronous reset while owner 5 holds
      do_reset();
      step(16'h0020);
      step(16'h0020);
      check("d032_own5", 32'(grant), 32'h0020);
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check("d032_async_g", 32'(grant), 32'd0);
      check("d032_async_v", 32'(grant_valid), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      step(16'h0020);
      check("d032_regrant", 32'(grant), 32'h0020);

      // random sticky-ish request traffic against the model
      r = '0;
      for (int k = 0; k < 10000; k++) begin
         if ($urandom_range(0, 2) == 0) r = r ^ oh($urandom_range(0, N_REQ - 1));
         if ($urandom_range(0, 199) == 0) r = '0;
         if ($urandom_range(0, 299) == 0) r = N_REQ'($urandom_range(0, 65535));
         step(r);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
